minhash_topk_sorter: RTL and testbench
======================================

Name: minhash_topk_sorter

Overview:
- Streaming bottom-K MinHash sorter.
- Sits between the hasher and the extender. Receives one (signature, index) pair per accepted beat for a fragment, and keeps the K smallest signatures in ascending order.
- After the fragment's last beat, it emits the retained pairs in order to the extender.
- Generalises the fixed 4-entry sorter:
  - parametrised depth K and widths;
  - valid/ready on both sides;
  - duplicate-signature suppression mode;
  - per-fragment occupancy reporting.

Parameters:
- SIG_W, 32, signature width in bits.
- IDX_W, 5, k-mer index width in bits.
- K, 4, number of retained minima. Legal range 1..16.
- POS_W, $clog2(K) (minimum 1), width of output rank field.
- DEDUP, 0. When 1, a signature equal to one already retained is dropped.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input pair valid
- in_ready  output  1  sorter can accept a pair
- in_sig  input  SIG_W  hash signature
- in_idx  input  IDX_W  k-mer index within the fragment
- in_last  input  1  final pair of the fragment
- out_valid  output  1  output pair valid
- out_ready  input  1  extender accepts the pair
- out_sig  output  SIG_W  retained signature
- out_idx  output  IDX_W  retained index
- out_pos  output  POS_W  rank of the pair, 0 = smallest
- out_last  output  1  final retained pair of the fragment
- occupancy  output  POS_W+1  number of valid slots, 0..K

Behaviour:
- Reset: asynchronous, active-low, applies immediately.
  - All slot valid bits are cleared.
  - State goes to COLLECT.
  - in_ready=1, out_valid=0, out_last=0, out_pos=0, out_sig=0, out_idx=0, occupancy=0.
  - Reset in any state discards any partial fragment.
- Storage: K slots, each holding {sig, idx, vld}, kept sorted ascending by sig. Valid slots always form a contiguous prefix starting at slot 0.
- State COLLECT: in_ready=1, out_valid=0. A beat is accepted when in_valid && in_ready, and is handled in one cycle:
  - The insertion position p is the first slot that is invalid or has sig > in_sig.
  - Ties are resolved by arrival order: the new pair goes after any equal entries.
  - Slots p..K-2 shift down by one. Slot K-1's content is lost if the array was full. The new pair is written to slot p.
  - If no such p exists (array full and in_sig >= slot[K-1].sig), the pair is discarded.
  - If DEDUP=1 and any valid slot has sig == in_sig, the pair is discarded and the array is unchanged.
  - occupancy updates the cycle after acceptance and saturates at K.
- Transition to DRAIN: on the cycle after an accepted beat with in_last=1. That beat is itself inserted or discarded first.
- State DRAIN: in_ready=0, out_valid=1. A read pointer r starts at 0.
  - Outputs show slot[r]: out_pos=r; out_last=1 when r == occupancy-1.
  - Outputs hold stable while out_valid && !out_ready.
  - On out_valid && out_ready, r increments.
  - On acceptance with out_last=1: all slots clear, occupancy becomes 0, and the state returns to COLLECT on the next cycle.
- Latency:
  - First out_valid occurs 1 cycle after the in_last beat is accepted.
  - With out_ready held high, a fragment drains in occupancy cycles.
  - in_ready returns 1 cycle after the out_last handshake.
  - Back-to-back fragments therefore have a gap of occupancy+1 cycles.
- Boundary conditions:
  - Fragment of a single beat with in_last: occupancy=1, so exactly one output with out_pos=0 and out_last=1.
  - Occupancy is always >=1 in DRAIN, because the in_last beat is never dropped on an empty array.
  - in_valid asserted during DRAIN is ignored, since in_ready=0. Upstream must hold the beat until in_ready returns.
  - Signatures of all-ones and all-zeros are ordinary values; there is no sentinel.
  - Comparisons are unsigned over SIG_W bits.
- out_* data values are don't-care while out_valid=0, but are driven to 0 after reset.

Test Plan:
- K=4, DEDUP=0; sigs 50,20,90,10,70,30(last) with idx 0..5, out_ready=1 → outputs (10,3),(20,1),(30,5),(50,0) with pos 0..3 and out_last on pos 3. First out_valid occurs 1 cycle after the last input beat.
- K=4, DEDUP=0; sigs 7,7,7(last) with idx 2,4,6 → (7,2),(7,4),(7,6), occupancy=3, out_last on the third output.
- K=4, DEDUP=1; sigs 7,3,7,3,9(last) → (3,1),(7,0),(9,4), occupancy=3.
- Backpressure: out_ready toggles 0,0,1 repeatedly → each pair holds stable for 3 cycles, there are no skips or duplicates, and in_ready=0 throughout DRAIN.
- Single-beat fragment sig=0xFFFFFFFF idx=31 last → one output with pos 0 and out_last=1. The next fragment is accepted 1 cycle after that handshake.
- Assert rst_n low mid-DRAIN after 2 of 4 outputs → out_valid=0 immediately, occupancy=0, in_ready=1. A fresh fragment then sorts correctly with no stale entries.

Source files
------------

// File: rtl/minhash_topk_sorter.sv
// Streaming bottom-K MinHash sorter: keeps the K smallest (sig, idx) pairs of a fragment
// in ascending order, then drains them in rank order to the extender.
module minhash_topk_sorter #(
    parameter int SIG_W = 32,
    parameter int IDX_W = 5,
    parameter int K     = 4,
    parameter int POS_W = (K > 1) ? $clog2(K) : 1,
    parameter int DEDUP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] in_sig,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig,
    output logic [IDX_W-1:0] out_idx,
    output logic [POS_W-1:0] out_pos,
    output logic             out_last,
    output logic [POS_W:0]   occupancy
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

    localparam logic [POS_W:0]   K_OCC   = (POS_W+1)'(K);
    localparam logic [POS_W:0]   OCC_ONE = (POS_W+1)'(1);
    localparam logic [POS_W-1:0] PTR_ONE = POS_W'(1);

    state_t             state_r, state_nxt_s;
    logic [SIG_W-1:0]   slot_sig_r [K];
    logic [IDX_W-1:0]   slot_idx_r [K];
    logic [K-1:0]       slot_vld_r;
    logic [SIG_W-1:0]   slot_sig_s [K];
    logic [IDX_W-1:0]   slot_idx_s [K];
    logic [K-1:0]       slot_vld_s;
    logic [SIG_W-1:0]   sh_sig_s   [K];
    logic [IDX_W-1:0]   sh_idx_s   [K];
    logic [K-1:0]       sh_vld_s;
    logic [POS_W:0]     occ_r, occ_nxt_s, ins_pos_s;
    logic [POS_W-1:0]   rd_ptr_r, rd_nxt_s;
    logic               in_ready_r, out_valid_r, out_last_r;
    logic [SIG_W-1:0]   out_sig_r;
    logic [IDX_W-1:0]   out_idx_r;
    logic [POS_W-1:0]   out_pos_r;
    logic               accept_s, out_fire_s, found_s, dup_s, keep_s, hit_s;

    assign accept_s   = in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && out_ready;
    assign rd_nxt_s   = rd_ptr_r + PTR_ONE;

    // Insertion point: first invalid slot or first slot strictly greater (ties keep arrival order)
    always_comb begin
        found_s   = 1'b0;
        dup_s     = 1'b0;
        hit_s     = 1'b0;
        ins_pos_s = '0;
        for (int i = 0; i < K; i++) begin
            hit_s     = !slot_vld_r[i] || (slot_sig_r[i] > in_sig);
            dup_s     = dup_s | (slot_vld_r[i] && (slot_sig_r[i] == in_sig));
            ins_pos_s = (!found_s && hit_s) ? (POS_W+1)'(i) : ins_pos_s;
            found_s   = found_s | hit_s;
        end
        keep_s    = accept_s && found_s && !((DEDUP != 0) && dup_s);
        occ_nxt_s = (keep_s && (occ_r < K_OCC)) ? (occ_r + OCC_ONE) : occ_r;
    end

    // Shifted-down copy of the array; slot K-1 falls off the end
    always_comb begin
        sh_sig_s[0] = slot_sig_r[0];
        sh_idx_s[0] = slot_idx_r[0];
        sh_vld_s[0] = slot_vld_r[0];
        for (int i = 1; i < K; i++) begin
            sh_sig_s[i] = slot_sig_r[i-1];
            sh_idx_s[i] = slot_idx_r[i-1];
            sh_vld_s[i] = slot_vld_r[i-1];
        end
    end

    // Post-insertion array contents
    always_comb begin
        slot_sig_s = slot_sig_r;
        slot_idx_s = slot_idx_r;
        slot_vld_s = slot_vld_r;
        for (int i = 0; i < K; i++) begin
            if (keep_s && ((POS_W+1)'(i) == ins_pos_s)) begin
                slot_sig_s[i] = in_sig;
                slot_idx_s[i] = in_idx;
                slot_vld_s[i] = 1'b1;
            end else if (keep_s && ((POS_W+1)'(i) > ins_pos_s)) begin
                slot_sig_s[i] = sh_sig_s[i];
                slot_idx_s[i] = sh_idx_s[i];
                slot_vld_s[i] = sh_vld_s[i];
            end else begin
                slot_sig_s[i] = slot_sig_r[i];
                slot_idx_s[i] = slot_idx_r[i];
                slot_vld_s[i] = slot_vld_r[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s && in_last) state_nxt_s = ST_DRAIN;
                else                     state_nxt_s = ST_COLLECT;
            end
            ST_DRAIN: begin
                if (out_fire_s && out_last_r) state_nxt_s = ST_COLLECT;
                else                          state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_COLLECT;
        else        state_r <= state_nxt_s;
    end

    // Slot storage, occupancy and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                slot_sig_r[i] <= '0;
                slot_idx_r[i] <= '0;
            end
            slot_vld_r  <= '0;
            occ_r       <= '0;
            rd_ptr_r    <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sig_r   <= '0;
            out_idx_r   <= '0;
            out_pos_r   <= '0;
            out_last_r  <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_COLLECT);
            out_valid_r <= (state_nxt_s == ST_DRAIN);
            case (state_r)
                ST_COLLECT: begin
                    slot_sig_r <= slot_sig_s;
                    slot_idx_r <= slot_idx_s;
                    slot_vld_r <= slot_vld_s;
                    occ_r      <= occ_nxt_s;
                    // Preload rank 0 from the post-insertion array so out_valid rises next cycle
                    if (accept_s && in_last) begin
                        rd_ptr_r   <= '0;
                        out_sig_r  <= slot_sig_s[0];
                        out_idx_r  <= slot_idx_s[0];
                        out_pos_r  <= '0;
                        out_last_r <= (occ_nxt_s == OCC_ONE);
                    end
                end
                ST_DRAIN: begin
                    if (out_fire_s && out_last_r) begin
                        slot_vld_r <= '0;
                        occ_r      <= '0;
                        out_last_r <= 1'b0;
                    end else if (out_fire_s) begin
                        rd_ptr_r   <= rd_nxt_s;
                        out_sig_r  <= slot_sig_r[rd_nxt_s];
                        out_idx_r  <= slot_idx_r[rd_nxt_s];
                        out_pos_r  <= rd_nxt_s;
                        out_last_r <= (((POS_W+1)'(rd_nxt_s) + OCC_ONE) == occ_r);
                    end
                end
                default: begin
                    slot_vld_r <= '0;
                    occ_r      <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sig   = out_sig_r;
    assign out_idx   = out_idx_r;
    assign out_pos   = out_pos_r;
    assign out_last  = out_last_r;
    assign occupancy = occ_r;

endmodule

// File: tb/tb_minhash_topk_sorter.sv
// Randomized self-checking bench: two sorter instances (DEDUP=0 and DEDUP=1, K=4)
// compared against a queue-based bottom-K reference model.
module tb_minhash_topk_sorter;

    localparam int K = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_sig    [2];
    logic [4:0]  in_idx    [2];
    logic        in_last   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_sig   [2];
    logic [4:0]  out_idx   [2];
    logic [1:0]  out_pos   [2];
    logic        out_last  [2];
    logic [2:0]  occupancy [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] frag_sig [$];
    logic [4:0]  frag_idx [$];
    logic [31:0] exp_sig  [$];
    logic [4:0]  exp_idx  [$];

    always #5 clk = ~clk;

    minhash_topk_sorter #(.SIG_W(32), .IDX_W(5), .K(K), .DEDUP(0)) u_nodup (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sig(in_sig[0]),
        .in_idx(in_idx[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sig(out_sig[0]),
        .out_idx(out_idx[0]), .out_pos(out_pos[0]), .out_last(out_last[0]),
        .occupancy(occupancy[0])
    );

    minhash_topk_sorter #(.SIG_W(32), .IDX_W(5), .K(K), .DEDUP(1)) u_dedup (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sig(in_sig[1]),
        .in_idx(in_idx[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sig(out_sig[1]),
        .out_idx(out_idx[1]), .out_pos(out_pos[1]), .out_last(out_last[1]),
        .occupancy(occupancy[1])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: insert after any equal entries, keep the K smallest
    task automatic build_expected(input int u);
        int j;
        bit dup;
        exp_sig.delete();
        exp_idx.delete();
        foreach (frag_sig[b]) begin
            dup = 1'b0;
            foreach (exp_sig[e]) if (exp_sig[e] == frag_sig[b]) dup = 1'b1;
            if (!(u == 1 && dup)) begin
                j = 0;
                while (j < exp_sig.size() && exp_sig[j] <= frag_sig[b]) j++;
                exp_sig.insert(j, frag_sig[b]);
                exp_idx.insert(j, frag_idx[b]);
                if (exp_sig.size() > K) begin
                    void'(exp_sig.pop_back());
                    void'(exp_idx.pop_back());
                end
            end
        end
    endtask

    task automatic drive_frag(input int u);
        int g;
        foreach (frag_sig[b]) begin
            @(negedge clk);
            in_valid[u] = 1'b1;
            in_sig[u]   = frag_sig[b];
            in_idx[u]   = frag_idx[b];
            in_last[u]  = (b == frag_sig.size() - 1);
            g = 0;
            while (!in_ready[u] && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) check_val("in_ready_wait", 64'(in_ready[u]), 64'd1);
        end
    endtask

    // bp: 0 = always ready, 1 = ready pattern 0,0,1, 2 = random
    task automatic drain(input int u, input int bp, input int stop_after);
        int  r = 0;
        int  cyc = 0;
        int  ph = 0;
        bit  fire;
        while (r < exp_sig.size() && r != stop_after && cyc < 300) begin
            @(negedge clk);
            case (bp)
                0:       out_ready[u] = 1'b1;
                1:       out_ready[u] = (ph == 2);
                default: out_ready[u] = 1'($urandom_range(0, 1));
            endcase
            ph = (ph + 1) % 3;
            in_valid[u] = 1'b1;
            in_sig[u]   = $urandom;
            in_idx[u]   = 5'($urandom);
            in_last[u]  = 1'b1;
            check_val(cyc == 0 ? "first_valid" : "out_valid", 64'(out_valid[u]), 64'd1);
            check_val("in_ready_drain", 64'(in_ready[u]), 64'd0);
            check_val("occupancy_drain", 64'(occupancy[u]), 64'(exp_sig.size()));
            if (out_valid[u]) begin
                check_val("out_sig", 64'(out_sig[u]), 64'(exp_sig[r]));
                check_val("out_idx", 64'(out_idx[u]), 64'(exp_idx[r]));
                check_val("out_pos", 64'(out_pos[u]), 64'(r));
                check_val("out_last", 64'(out_last[u]), 64'(r == exp_sig.size() - 1));
            end
            fire = out_valid[u] && out_ready[u];
            @(posedge clk);
            if (fire) r++;
            cyc++;
        end
        if (cyc >= 300) check_val("drain_timeout", 64'(r), 64'(exp_sig.size()));
        if (stop_after < 0) begin
            @(negedge clk);
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b0;
            check_val("ready_after_drain", 64'(in_ready[u]), 64'd1);
            check_val("valid_after_drain", 64'(out_valid[u]), 64'd0);
            check_val("occ_after_drain", 64'(occupancy[u]), 64'd0);
        end
    endtask

    task automatic run_frag(input int u, input int bp, input int stop_after);
        build_expected(u);
        drive_frag(u);
        drain(u, bp, stop_after);
    endtask

    task automatic set_frag(input logic [31:0] s [$], input logic [4:0] ix [$]);
        frag_sig = s;
        frag_idx = ix;
    endtask

    task automatic check_idle(input string tag, input int u);
        check_val({tag, "_in_ready"}, 64'(in_ready[u]), 64'd1);
        check_val({tag, "_out_valid"}, 64'(out_valid[u]), 64'd0);
        check_val({tag, "_occupancy"}, 64'(occupancy[u]), 64'd0);
    endtask

    initial begin
        int n;
        int u;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_sig[i] = '0; in_idx[i] = '0;
            in_last[i] = 1'b0; out_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_idle("reset", i);
            check_val("reset_out_sig", 64'(out_sig[i]), 64'd0);
            check_val("reset_out_idx", 64'(out_idx[i]), 64'd0);
            check_val("reset_out_pos", 64'(out_pos[i]), 64'd0);
            check_val("reset_out_last", 64'(out_last[i]), 64'd0);
        end
        rst_n = 1'b1;

        set_frag('{32'd50, 32'd20, 32'd90, 32'd10, 32'd70, 32'd30}, '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
        run_frag(0, 0, -1);
        set_frag('{32'd7, 32'd7, 32'd7}, '{5'd2, 5'd4, 5'd6});
        run_frag(0, 0, -1);
        set_frag('{32'd7, 32'd3, 32'd7, 32'd3, 32'd9}, '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4});
        run_frag(1, 0, -1);
        set_frag('{32'd5, 32'd1, 32'd8, 32'd0, 32'hFFFF_FFFF, 32'd2}, '{5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4});
        run_frag(0, 1, -1);
        set_frag('{32'hFFFF_FFFF}, '{5'd31});
        run_frag(0, 0, -1);
        set_frag('{32'd40, 32'd10, 32'd30, 32'd20}, '{5'd1, 5'd2, 5'd3, 5'd4});
        run_frag(0, 0, -1);

        // Reset in the middle of a drain
        set_frag('{32'd400, 32'd100, 32'd300, 32'd200}, '{5'd0, 5'd1, 5'd2, 5'd3});
        run_frag(0, 0, 2);
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("mid_drain_reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_frag('{32'd3, 32'd1, 32'd2}, '{5'd10, 5'd11, 5'd12});
        run_frag(0, 0, -1);

        for (int t = 0; t < 30; t++) begin
            u = t % 2;
            n = $urandom_range(1, 10);
            frag_sig.delete();
            frag_idx.delete();
            for (int b = 0; b < n; b++) begin
                case ($urandom_range(0, 3))
                    0:       frag_sig.push_back($urandom);
                    1:       frag_sig.push_back(32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
                    default: frag_sig.push_back(32'($urandom_range(0, 12)));
                endcase
                frag_idx.push_back(5'($urandom));
            end
            run_frag(u, $urandom_range(0, 2), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
